// File: rtl/puf_vote_ctrl_if.sv
// Handshake/bus bundle for puf_vote_ctrl: host request, PUF drive/response and key handshake.
// The unstable signal exists only when PUF_VOTE_STABILITY_EN is defined.
interface puf_vote_ctrl_if;
    logic       start;
    logic [7:0] challenge;
    logic       busy;
    logic       puf_reset;
    logic       puf_enable;
    logic [7:0] puf_challenge;
    logic [7:0] puf_response;
    logic       puf_done;
    logic [7:0] key;
    logic       key_valid;
    logic       key_ready;
    logic       timeout_err;
`ifdef PUF_VOTE_STABILITY_EN
    logic [7:0] unstable;
`endif

    modport slave (
`ifdef PUF_VOTE_STABILITY_EN
        output unstable,
`endif
        input  start, challenge, puf_response, puf_done, key_ready,
        output busy, puf_reset, puf_enable, puf_challenge, key, key_valid, timeout_err
    );

    modport master (
`ifdef PUF_VOTE_STABILITY_EN
        input  unstable,
`endif
        output start, challenge, puf_response, puf_done, key_ready,
        input  busy, puf_reset, puf_enable, puf_challenge, key, key_valid, timeout_err
    );
endinterface

// File: rtl/puf_vote_ctrl.sv
// Majority-vote key extraction over REPEATS PUF evaluations with per-wait timeout.
// Define PUF_VOTE_STABILITY_EN to build per-bit stability reporting (bus.unstable).
module puf_vote_ctrl #(
    parameter int unsigned REPEATS = 5,
    parameter int unsigned TIMEOUT = 1000
) (
    input logic            clk,
    input logic            reset_n,
    puf_vote_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_PRST, S_ARM, S_CAPT, S_REL, S_DECIDE, S_OUT
    } state_e;

    localparam logic [3:0]  REPS      = 4'(REPEATS);
    localparam logic [3:0]  HALF      = 4'(REPEATS / 2);
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  chal_q, chal_d;
    logic [7:0]  key_q, key_d;
    logic [3:0]  votes_q [8];
    logic [3:0]  votes_d [8];
    logic [3:0]  samp_q, samp_d;
    logic [15:0] wait_q, wait_d;
    logic        err_q, err_d;
    logic [1:0]  sync_q;
    logic        done_s;
`ifdef PUF_VOTE_STABILITY_EN
    logic [7:0]  unst_q, unst_d;
`endif

    assign done_s = sync_q[1];

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            chal_q  <= '0;
            key_q   <= '0;
            samp_q  <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
            sync_q  <= '0;
            // NOTE: the vote counters are reset so an aborted run leaves no residue.
            for (int i = 0; i < 8; i++) votes_q[i] <= '0;
`ifdef PUF_VOTE_STABILITY_EN
            unst_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            chal_q  <= chal_d;
            key_q   <= key_d;
            samp_q  <= samp_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            sync_q  <= {sync_q[0], bus.puf_done};
            votes_q <= votes_d;
`ifdef PUF_VOTE_STABILITY_EN
            unst_q  <= unst_d;
`endif
        end
    end

    // NOTE: every next-state signal takes its hold value first, so no latches form.
    always_comb begin
        state_d = state_q;
        chal_d  = chal_q;
        key_d   = key_q;
        samp_d  = samp_q;
        wait_d  = wait_q;
        err_d   = err_q;
        votes_d = votes_q;
`ifdef PUF_VOTE_STABILITY_EN
        unst_d  = unst_q;
`endif
        unique case (state_q)
            S_IDLE: if (bus.start) begin
                chal_d  = bus.challenge;
                samp_d  = '0;
                wait_d  = '0;
                err_d   = 1'b0;
                for (int i = 0; i < 8; i++) votes_d[i] = '0;
                state_d = S_PRST;
            end
            // wait_q doubles as the two-cycle PUF reset timer
            S_PRST: if (wait_q[0]) begin
                wait_d  = '0;
                state_d = S_ARM;
            end else begin
                wait_d  = wait_q + 16'd1;
            end
            S_ARM: if (done_s) begin
                state_d = S_CAPT;
            end else if (wait_q == WAIT_LAST) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                wait_d  = wait_q + 16'd1;
            end
            S_CAPT: begin
                for (int i = 0; i < 8; i++)
                    votes_d[i] = votes_q[i] + {3'b000, bus.puf_response[i]};
                samp_d  = samp_q + 4'd1;
                wait_d  = '0;
                state_d = S_REL;
            end
            S_REL: if (!done_s) begin
                wait_d  = '0;
                state_d = (samp_q < REPS) ? S_PRST : S_DECIDE;
            end else if (wait_q == WAIT_LAST) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                wait_d  = wait_q + 16'd1;
            end
            S_DECIDE: begin
                for (int i = 0; i < 8; i++) begin
                    key_d[i] = (votes_q[i] > HALF);
`ifdef PUF_VOTE_STABILITY_EN
                    unst_d[i] = (votes_q[i] != 4'd0) && (votes_q[i] != REPS);
`endif
                end
                state_d = S_OUT;
            end
            S_OUT: if (bus.key_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // PUF drive decodes straight from the async-reset state, so enable drops the moment reset asserts
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.puf_reset     = (state_q == S_PRST);
    assign bus.puf_enable    = (state_q == S_ARM) || (state_q == S_CAPT);
    assign bus.puf_challenge = chal_q;
    assign bus.key           = key_q;
    assign bus.key_valid     = (state_q == S_OUT);
    assign bus.timeout_err   = err_q;
`ifdef PUF_VOTE_STABILITY_EN
    assign bus.unstable      = unst_q;
`endif
endmodule
